// File: rtl/fp18_div_seq.sv
// Sequential 18-bit floating-point divider R = X / Y (sign, 6-bit exponent, 11-bit mantissa).
// Radix-2 restoring mantissa divide with valid/ready handshakes and fixed 16-edge latency.
module fp18_div_seq #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 11,
    parameter int BIAS  = 31,
    parameter int ITER  = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   X,
    input  logic [EXP_W+MAN_W:0]   Y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   R,
    output logic                   div_by_zero
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state, w_next;
    logic [W-1:0]     r_x, r_y, r_res;
    logic [MAN_W+1:0] r_rem;
    logic [ITER-1:0]  r_q;
    logic [3:0]       r_cnt;
    logic             r_dbz, r_out_valid;

    logic [MAN_W:0]   w_my;
    logic             w_ge;
    logic [MAN_W+1:0] w_sub, w_sel, w_rem_nxt;

    logic [EXP_W-1:0] w_xe, w_ye;
    logic             w_sign, w_x_zero, w_y_zero, w_x_inf, w_y_inf, w_x_nan, w_y_nan;
    logic             w_int, w_guard, w_sticky, w_inc;
    logic [MAN_W-1:0] w_mant;
    logic [MAN_W:0]   w_mant_sum;
    logic [7:0]       w_e_base, w_e_raw, w_e_rnd;
    logic [W-1:0]     w_inf, w_zero, w_res;
    logic             w_dbz;

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = r_out_valid;
    assign R           = r_res;
    assign div_by_zero = r_dbz;

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next = S_DIV; else w_next = S_IDLE;
            S_DIV:  if (r_cnt == 4'(ITER - 1)) w_next = S_NORM; else w_next = S_DIV;
            S_NORM: w_next = S_DONE;
            S_DONE: if (r_out_valid && out_ready) w_next = S_IDLE; else w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // One restoring-division step: trial subtract, keep on success, shift left
    always_comb begin
        w_my = {1'b1, r_y[MAN_W-1:0]};
        w_ge = (r_rem >= {1'b0, w_my});
        w_sub = r_rem - {1'b0, w_my};
        if (w_ge) w_sel = w_sub; else w_sel = r_rem;
        w_rem_nxt = w_sel << 1;
    end

    // Operand classification, normalise, round-to-nearest-even, pack and special-case override
    always_comb begin
        w_xe     = r_x[W-2:MAN_W];
        w_ye     = r_y[W-2:MAN_W];
        w_sign   = r_x[W-1] ^ r_y[W-1];
        w_x_zero = (w_xe == '0);
        w_y_zero = (w_ye == '0);
        w_x_inf  = (w_xe == EXP_MAX) && (r_x[MAN_W-1:0] == '0);
        w_y_inf  = (w_ye == EXP_MAX) && (r_y[MAN_W-1:0] == '0);
        w_x_nan  = (w_xe == EXP_MAX) && (r_x[MAN_W-1:0] != '0);
        w_y_nan  = (w_ye == EXP_MAX) && (r_y[MAN_W-1:0] != '0);

        w_int    = r_q[ITER-1];
        w_e_base = {2'b00, w_xe} - {2'b00, w_ye} + 8'(BIAS);
        if (w_int) begin
            w_mant   = r_q[ITER-2 -: MAN_W];
            w_guard  = r_q[1];
            w_sticky = r_q[0] | (|r_rem);
            w_e_raw  = w_e_base;
        end else begin
            w_mant   = r_q[ITER-3 -: MAN_W];
            w_guard  = r_q[0];
            w_sticky = |r_rem;
            w_e_raw  = w_e_base - 8'd1;
        end
        w_inc      = w_guard & (w_sticky | w_mant[0]);
        w_mant_sum = {1'b0, w_mant} + {{MAN_W{1'b0}}, w_inc};
        w_e_rnd    = w_e_raw + {7'd0, w_mant_sum[MAN_W]};

        w_inf  = {w_sign, EXP_MAX, {MAN_W{1'b0}}};
        w_zero = {w_sign, {(W-1){1'b0}}};
        w_dbz  = 1'b0;
        if ($signed(w_e_rnd) >= $signed({2'b00, EXP_MAX})) begin
            w_res = w_inf;
        end else if ($signed(w_e_rnd) <= $signed(8'd0)) begin
            w_res = w_zero;
        end else begin
            w_res = {w_sign, w_e_rnd[EXP_W-1:0], w_mant_sum[MAN_W-1:0]};
        end

        if (w_x_nan || w_y_nan || (w_x_zero && w_y_zero) || (w_x_inf && w_y_inf)) begin
            w_res = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (w_y_zero && !w_x_inf) begin
            w_res = w_inf;
            w_dbz = 1'b1;
        end else if (w_x_inf) begin
            w_res = w_inf;
        end else if (w_x_zero || w_y_inf) begin
            w_res = w_zero;
        end else begin
            w_res = w_res;
        end
    end

    // State, datapath and output registers; out_valid follows DONE entry by one edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_cnt       <= 4'd0;
            r_res       <= '0;
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x   <= X;
                        r_y   <= Y;
                        r_rem <= {2'b01, X[MAN_W-1:0]};
                        r_q   <= '0;
                        r_cnt <= 4'd0;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= {r_q[ITER-2:0], w_ge};
                    r_cnt <= r_cnt + 4'd1;
                end
                S_NORM: begin
                    r_res <= w_res;
                    r_dbz <= w_dbz;
                end
                S_DONE: r_out_valid <= ~(r_out_valid & out_ready);
                default: r_out_valid <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_fp18_div_seq.sv
// Self-checking bench for fp18_div_seq: arithmetic reference model, per-cycle compare
// process, directed literal cases and randomized operands with handshake stress.
module tb_fp18_div_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, div_by_zero;
    logic [17:0] X, Y, R;

    int n_checks = 0;
    int n_err    = 0;

    logic        m_busy = 1'b0;
    int          m_cnt  = 0;
    logic [18:0] m_exp  = '0;

    fp18_div_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .X(X), .Y(Y), .out_valid(out_valid), .out_ready(out_ready),
        .R(R), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference result {div_by_zero, R} from plain integer arithmetic
    function automatic logic [18:0] ref_fn(input logic [17:0] x, input logic [17:0] y);
        int ex, ey, mx, my, q, rem, e, man, g, st;
        logic s, xz, yz, xi, yi, xn, yn;
        ex = int'(x[16:11]);
        ey = int'(y[16:11]);
        s  = x[17] ^ y[17];
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 63) && (x[10:0] == 11'd0);
        yi = (ey == 63) && (y[10:0] == 11'd0);
        xn = (ex == 63) && (x[10:0] != 11'd0);
        yn = (ey == 63) && (y[10:0] != 11'd0);
        if (xn || yn || (xz && yz) || (xi && yi)) return {1'b0, 18'h1FC00};
        if (yz && !xi) return {1'b1, s, 6'h3F, 11'h000};
        if (xi) return {1'b0, s, 6'h3F, 11'h000};
        if (xz || yi) return {1'b0, s, 17'h00000};
        mx  = 2048 + int'(x[10:0]);
        my  = 2048 + int'(y[10:0]);
        q   = (mx * 8192) / my;
        rem = (mx * 8192) % my;
        if (q >= 8192) begin
            man = (q / 4) % 2048;
            g   = (q / 2) % 2;
            st  = ((q % 2) != 0 || rem != 0) ? 1 : 0;
            e   = ex - ey + 31;
        end else begin
            man = (q / 2) % 2048;
            g   = q % 2;
            st  = (rem != 0) ? 1 : 0;
            e   = ex - ey + 30;
        end
        if (g == 1 && (st == 1 || (man % 2) == 1)) man++;
        if (man == 2048) begin
            man = 0;
            e++;
        end
        if (e >= 63) return {1'b0, s, 6'h3F, 11'h000};
        if (e <= 0) return {1'b0, s, 17'h00000};
        return {1'b0, s, 6'(e), 11'(man)};
    endfunction

    function automatic logic [17:0] rnd_op();
        logic [5:0] e;
        logic [10:0] m;
        int c;
        c = $urandom_range(0, 9);
        m = 11'($urandom);
        if (c == 0) e = 6'd0;
        else if (c == 1) e = 6'd63;
        else if (c < 6) e = 6'($urandom_range(20, 42));
        else e = 6'($urandom_range(1, 62));
        if (c == 1 && $urandom_range(0, 1) == 1) m = 11'd0;
        return {1'($urandom), e, m};
    endfunction

    // Transaction-level model: busy flag and edge count since accept
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_exp  <= ref_fn(X, Y);
            end
        end else if (m_cnt >= 16) begin
            if (out_ready) m_busy <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // Compare process: every cycle outside reset
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
            chk("out_valid", {31'd0, out_valid}, {31'd0, (m_busy && m_cnt >= 16)});
            if (m_busy && m_cnt >= 16) begin
                chk("R", {14'd0, R}, {14'd0, m_exp[17:0]});
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_exp[18]});
            end
        end
    end

    task automatic do_op(input logic [17:0] x, input logic [17:0] y, input int stall,
                         input bit junk, output logic [17:0] r_got, output logic d_got);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", {31'd0, in_ready}, 32'd1);
        X = x;
        Y = y;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            if (junk) begin
                in_valid = 1'($urandom_range(0, 1));
                X = 18'($urandom);
                Y = 18'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("latency", n, 32'd16);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        r_got = R;
        d_got = div_by_zero;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ready_after_hs", {31'd0, in_ready}, 32'd1);
    endtask

    logic [17:0] tx [8] = '{18'h10C00, 18'h0F800, 18'h30C00, 18'h0F800,
                            18'h00000, 18'h1F800, 18'h1F7FF, 18'h00800};
    logic [17:0] ty [8] = '{18'h10000, 18'h10400, 18'h10000, 18'h00000,
                            18'h00000, 18'h1F800, 18'h00800, 18'h1F7FF};
    logic [17:0] tr [8] = '{18'h10400, 18'h0EAAB, 18'h30400, 18'h1F800,
                            18'h1FC00, 18'h1FC00, 18'h1F800, 18'h00000};
    logic        td [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        logic [17:0] rg, x, y;
        logic        dg;
        logic [18:0] mv;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        X = 18'd0;
        Y = 18'd0;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_R", {14'd0, R}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            mv = ref_fn(tx[i], ty[i]);
            chk("model_R", {14'd0, mv[17:0]}, {14'd0, tr[i]});
            chk("model_dbz", {31'd0, mv[18]}, {31'd0, td[i]});
            do_op(tx[i], ty[i], (i == 0) ? 5 : 0, (i == 1), rg, dg);
            chk("dut_R", {14'd0, rg}, {14'd0, tr[i]});
            chk("dut_dbz", {31'd0, dg}, {31'd0, td[i]});
        end

        X = 18'h10C00;
        Y = 18'h10000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_R", {14'd0, R}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(18'h10C00, 18'h10000, 1, 1'b0, rg, dg);
        chk("post_rst_R", {14'd0, rg}, 32'h10400);

        for (int k = 0; k < 40; k++) begin
            x = rnd_op();
            y = rnd_op();
            do_op(x, y, $urandom_range(0, 3), 1'($urandom_range(0, 1)), rg, dg);
            mv = ref_fn(x, y);
            chk("rand_R", {14'd0, rg}, {14'd0, mv[17:0]});
            chk("rand_dbz", {31'd0, dg}, {31'd0, mv[18]});
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
